// File: rtl/lsu_pkg.sv
// Shared types, encodings and helpers for the load/store unit.
// The ERR state only exists when LSU_ALIGN_CHECK_EN is defined.
package lsu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANE_W = 8;

    // 2'b11 is reserved and is handled as a word access
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        DONE = 3'd3
`ifdef LSU_ALIGN_CHECK_EN
        ,
        ERR  = 3'd4
`endif
    } state_e;

    typedef struct packed {
        logic              wr;
        logic [1:0]        size;
        logic              sext;
        logic [1:0]        lane;
        logic [DATA_W-1:0] wdata;
    } req_t;

    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        return ((size == SZ_HALF) && lane[0]) || (size[1] && (lane != 2'b00));
    endfunction

    // Drop the low address bits a half or word access is not allowed to use
    function automatic logic [1:0] force_lane(input logic [1:0] size, input logic [1:0] lane);
        if (size[1])
            return 2'b00;
        else if (size == SZ_HALF)
            return {lane[1], 1'b0};
        else
            return lane;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// CPU request/response and data-memory port of the load/store unit.
// master = CPU side plus memory read data, slave = the load/store unit.
interface lsu_mem_ctrl_if #(
    parameter int unsigned ADDR_W = 10
);
    import lsu_pkg::*;

    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic              sext;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_din;
    logic              dm_we;
    logic [DATA_W-1:0] dm_dout;

    modport master (
        output req, wr, size, sext, addr, wdata, dm_dout,
        input  busy, done, err, rdata, dm_addr, dm_din, dm_we
    );

    modport slave (
        input  req, wr, size, sext, addr, wdata, dm_dout,
        output busy, done, err, rdata, dm_addr, dm_din, dm_we
    );

endinterface

// File: rtl/lsu_lane_merge.sv
// Combinational lane logic: store merge into a memory word and load extraction
// with sign/zero extension.
module lsu_lane_merge
    import lsu_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        size,
    input  logic              sext,
    input  logic [1:0]        lane,
    output logic [DATA_W-1:0] merged_c,
    output logic [DATA_W-1:0] loaded_c
);

    logic [LANE_W-1:0]   b_lane;
    logic [2*LANE_W-1:0] h_lane;

    // Store: replace only the addressed lane of the current word
    always_comb begin
        merged_c = word;
        case (size)
            SZ_BYTE: merged_c[{lane, 3'b000} +: LANE_W]   = wdata[LANE_W-1:0];
            SZ_HALF: merged_c[{lane[1], 4'b0000} +: 2*LANE_W] = wdata[2*LANE_W-1:0];
            default: merged_c = wdata;
        endcase
    end

    // Load: pick the addressed lane and extend it
    always_comb begin
        b_lane = word[{lane, 3'b000} +: LANE_W];
        h_lane = word[{lane[1], 4'b0000} +: 2*LANE_W];
        case (size)
            SZ_BYTE: loaded_c = {{(DATA_W-LANE_W){sext & b_lane[LANE_W-1]}}, b_lane};
            SZ_HALF: loaded_c = {{(DATA_W-2*LANE_W){sext & h_lane[2*LANE_W-1]}}, h_lane};
            default: loaded_c = word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for the word-wide data memory: sub-word loads by extraction,
// sub-word stores by read-modify-write. LSU_ALIGN_CHECK_EN enables misalignment errors.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    lsu_mem_ctrl_if.slave bus
);

    state_e            state, state_d;
    req_t              req_q, req_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              dm_we_q, dm_we_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] dm_din_q, dm_din_d;
    logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
    logic [1:0]        lane_in;
    logic [DATA_W-1:0] merged_c;
    logic [DATA_W-1:0] loaded_c;

`ifdef LSU_ALIGN_CHECK_EN
    assign lane_in = bus.addr[1:0];
`else
    assign lane_in = force_lane(bus.size, bus.addr[1:0]);
`endif

    lsu_lane_merge u_lane_merge (
        .word     (bus.dm_dout),
        .wdata    (req_q.wdata),
        .size     (req_q.size),
        .sext     (req_q.sext),
        .lane     (req_q.lane),
        .merged_c (merged_c),
        .loaded_c (loaded_c)
    );

    // Next state plus next values of every registered output
    always_comb begin
        state_d   = state;
        req_d     = req_q;
        rdata_d   = rdata_q;
        dm_din_d  = dm_din_q;
        dm_addr_d = dm_addr_q;
        err_d     = 1'b0;

        case (state)
            IDLE: begin
                if (bus.req) begin
                    req_d     = '{wr: bus.wr, size: bus.size, sext: bus.sext,
                                  lane: lane_in, wdata: bus.wdata};
                    dm_addr_d = {bus.addr[ADDR_W-1:2], 2'b00};
`ifdef LSU_ALIGN_CHECK_EN
                    if (misaligned(bus.size, bus.addr[1:0]))
                        state_d = ERR;
                    else
`endif
                    if (!bus.wr)
                        state_d = RD;
                    else if (is_word(bus.size)) begin
                        state_d  = WR;
                        dm_din_d = bus.wdata;
                    end else
                        state_d = RD;
                end
            end
            RD: begin
                if (req_q.wr) begin
                    dm_din_d = merged_c;
                    state_d  = WR;
                end else begin
                    rdata_d = loaded_c;
                    state_d = DONE;
                end
            end
            WR:   state_d = DONE;
            DONE: state_d = IDLE;
`ifdef LSU_ALIGN_CHECK_EN
            ERR:  state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase

        busy_d  = (state_d != IDLE);
        dm_we_d = (state_d == WR);
        done_d  = (state_d == DONE);
`ifdef LSU_ALIGN_CHECK_EN
        err_d   = (state_d == ERR);
        done_d  = done_d | err_d;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            dm_we_q   <= 1'b0;
            rdata_q   <= '0;
            dm_din_q  <= '0;
            dm_addr_q <= '0;
        end else begin
            state     <= state_d;
            req_q     <= req_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            dm_we_q   <= dm_we_d;
            rdata_q   <= rdata_d;
            dm_din_q  <= dm_din_d;
            dm_addr_q <= dm_addr_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.dm_we   = dm_we_q;
    assign bus.rdata   = rdata_q;
    assign bus.dm_din  = dm_din_q;
    assign bus.dm_addr = dm_addr_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl against a byte-array reference memory.
// Expectations follow LSU_ALIGN_CHECK_EN the same way the design does.
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    localparam int unsigned AW = 10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lsu_mem_ctrl_if #(.ADDR_W(AW)) bus ();

    lsu_mem_ctrl #(.ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Data memory: combinational read, whole-word write on posedge
    logic [31:0] mem [256];
    logic        pre_en;
    logic [7:0]  pre_idx;
    logic [31:0] pre_val;

    assign bus.dm_dout = mem[bus.dm_addr[AW-1:2]];

    always @(posedge clk) begin
        if (bus.dm_we)
            mem[bus.dm_addr[AW-1:2]] <= bus.dm_din;
        else if (pre_en)
            mem[pre_idx] <= pre_val;
    end

    logic [7:0]  refm [1024];
    logic [31:0] model_rdata;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [31:0] ref_word(input int base);
        return {refm[base+3], refm[base+2], refm[base+1], refm[base]};
    endfunction

    task automatic preset(input logic [9:0] a, input logic [31:0] v);
        int base;
        base = int'({a[9:2], 2'b00});
        @(negedge clk);
        pre_en  = 1'b1;
        pre_idx = a[9:2];
        pre_val = v;
        for (int i = 0; i < 4; i++) refm[base+i] = 8'(v >> (8*i));
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // One access with full protocol checking against the byte-level model
    task automatic run_op(input string name, input logic w, input logic [1:0] sz,
                          input logic sx, input logic [9:0] a, input logic [31:0] wd);
        int ea, base, lat, exp_we, we_cnt, done_cyc, h, nb;
        logic mis;
        logic [31:0] exp_word;
        mis = 1'b0;
        ea  = int'(a);
`ifdef LSU_ALIGN_CHECK_EN
        mis = ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
`else
        if (sz[1]) ea = ea & ~3;
        else if (sz == 2'b01) ea = ea & ~1;
`endif
        base   = ea & ~3;
        lat    = mis ? 1 : (!w ? 2 : (sz[1] ? 2 : 3));
        exp_we = (w && !mis) ? 1 : 0;
        if (!w && !mis) begin
            if (sz == 2'b00) begin
                h = int'(refm[ea]);
                if (sx && h >= 128) h = h - 256;
            end else if (sz == 2'b01) begin
                h = int'(refm[ea]) + 256 * int'(refm[ea+1]);
                if (sx && h >= 32768) h = h - 65536;
            end else
                h = int'(ref_word(ea));
            model_rdata = 32'(h);
        end
        if (w && !mis) begin
            nb = (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
            for (int i = 0; i < nb; i++) refm[ea+i] = 8'(wd >> (8*i));
        end
        exp_word = ref_word(base);

        @(negedge clk);
        bus.req = 1'b1; bus.wr = w; bus.size = sz; bus.sext = sx; bus.addr = a; bus.wdata = wd;
        @(posedge clk);
        @(negedge clk);
        bus.req  = 1'b0;
        we_cnt   = 0;
        done_cyc = 0;
        for (int c = 1; c <= 6 && done_cyc == 0; c++) begin
            if (c > 1) @(negedge clk);
            if (bus.dm_we === 1'b1) begin
                we_cnt++;
                checks++;
                if (bus.dm_addr !== 10'(base) || bus.dm_din !== exp_word) begin
                    errors++;
                    $display("FAIL %s write: addr=%h din=%h want addr=%h din=%h",
                             name, bus.dm_addr, bus.dm_din, 10'(base), exp_word);
                end
            end
            if (bus.done === 1'b1) done_cyc = c;
        end
        checks++;
        if (done_cyc != lat) begin
            errors++;
            $display("FAIL %s latency: got=%0d want=%0d", name, done_cyc, lat);
        end
        checks++;
        if (bus.err !== mis) begin
            errors++;
            $display("FAIL %s err: got=%b want=%b", name, bus.err, mis);
        end
        checks++;
        if (we_cnt != exp_we) begin
            errors++;
            $display("FAIL %s dm_we pulses: got=%0d want=%0d", name, we_cnt, exp_we);
        end
        checks++;
        if (bus.rdata !== model_rdata) begin
            errors++;
            $display("FAIL %s rdata: got=%h want=%h", name, bus.rdata, model_rdata);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after done: done=%b busy=%b want 0 0", name, bus.done, bus.busy);
        end
        if (w) begin
            checks++;
            if (mem[base >> 2] !== exp_word) begin
                errors++;
                $display("FAIL %s memory: got=%h want=%h", name, mem[base >> 2], exp_word);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req = 1'b0; bus.wr = 1'b0; bus.size = 2'b00; bus.sext = 1'b0;
        bus.addr = '0; bus.wdata = '0;
        pre_en = 1'b0; pre_idx = '0; pre_val = '0;
        model_rdata = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.err, bus.dm_we} !== 4'b0000) begin
            errors++;
            $display("FAIL reset flags: busy/done/err/we=%b want 0000",
                     {bus.busy, bus.done, bus.err, bus.dm_we});
        end
        checks++;
        if (bus.rdata !== 32'h0 || bus.dm_din !== 32'h0 || bus.dm_addr !== 10'h0) begin
            errors++;
            $display("FAIL reset data: rdata=%h din=%h addr=%h want 0",
                     bus.rdata, bus.dm_din, bus.dm_addr);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_loads();
        preset(10'h010, 32'h8899AABB);
        run_op("lw", 1'b0, 2'b10, 1'b0, 10'h010, 32'h0);
        checks++;
        if (bus.rdata !== 32'h8899AABB) begin
            errors++; $display("FAIL lw value: got=%h want=8899aabb", bus.rdata);
        end
        run_op("lb", 1'b0, 2'b00, 1'b1, 10'h013, 32'h0);
        checks++;
        if (bus.rdata !== 32'hFFFFFF88) begin
            errors++; $display("FAIL lb value: got=%h want=ffffff88", bus.rdata);
        end
        run_op("lbu", 1'b0, 2'b00, 1'b0, 10'h013, 32'h0);
        checks++;
        if (bus.rdata !== 32'h00000088) begin
            errors++; $display("FAIL lbu value: got=%h want=00000088", bus.rdata);
        end
        run_op("lh", 1'b0, 2'b01, 1'b1, 10'h012, 32'h0);
        checks++;
        if (bus.rdata !== 32'hFFFF8899) begin
            errors++; $display("FAIL lh value: got=%h want=ffff8899", bus.rdata);
        end
    endtask

    task automatic test_sb_rmw();
        preset(10'h020, 32'h11223344);
        run_op("sb", 1'b1, 2'b00, 1'b0, 10'h021, 32'hFFFFFFAB);
        checks++;
        if (mem[8] !== 32'h1122AB44) begin
            errors++; $display("FAIL sb word: got=%h want=1122ab44", mem[8]);
        end
    endtask

    task automatic test_sw_sh();
        run_op("sw", 1'b1, 2'b10, 1'b0, 10'h020, 32'hDEADBEEF);
        run_op("sh", 1'b1, 2'b01, 1'b0, 10'h022, 32'h0000CAFE);
        checks++;
        if (mem[8] !== 32'hCAFEBEEF) begin
            errors++; $display("FAIL sh word: got=%h want=cafebeef", mem[8]);
        end
    endtask

    task automatic test_misalign();
        run_op("lw_mis", 1'b0, 2'b10, 1'b0, 10'h011, 32'h0);
        run_op("sh_mis", 1'b1, 2'b01, 1'b0, 10'h023, 32'h00001357);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        exp = ref_word(16);
        @(negedge clk);
        bus.req = 1'b1; bus.wr = 1'b0; bus.size = 2'b10; bus.sext = 1'b0; bus.addr = 10'h010;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            checks++;
            if (bus.done !== ((c == 2) || (c == 5)) || bus.busy !== (c != 3)) begin
                errors++;
                $display("FAIL b2b cycle %0d: done=%b busy=%b", c, bus.done, bus.busy);
            end
            if (c == 4) bus.req = 1'b0;
        end
        model_rdata = exp;
        checks++;
        if (bus.rdata !== exp) begin
            errors++; $display("FAIL b2b rdata: got=%h want=%h", bus.rdata, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_store();
        preset(10'h030, 32'h01020304);
        @(negedge clk);
        bus.req = 1'b1; bus.wr = 1'b1; bus.size = 2'b10; bus.addr = 10'h030; bus.wdata = 32'hA5A5A5A5;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        checks++;
        if (bus.dm_we !== 1'b1) begin
            errors++; $display("FAIL rst_mid we before reset: got=%b want=1", bus.dm_we);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.dm_we !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid async: we=%b busy=%b want 0 0", bus.dm_we, bus.busy);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_rdata = '0;
        checks++;
        if (mem[12] !== 32'h01020304) begin
            errors++; $display("FAIL rst_mid memory: got=%h want=01020304", mem[12]);
        end
        run_op("post_rst_lw", 1'b0, 2'b10, 1'b0, 10'h030, 32'h0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 64; i++) preset(10'(i * 4), $urandom);
        for (int i = 0; i < 40; i++)
            run_op("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 10'($urandom_range(0, 255)), $urandom);
    endtask

    initial begin
        test_reset();
        test_loads();
        test_sb_rmw();
        test_sw_sh();
        test_misalign();
        test_back_to_back();
        test_reset_mid_store();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
